// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared sizing constants for the single-clock FIFO controller that drives an external 256x8 RAM.
package ram_fifo_ctrl_pkg;
  localparam int DEPTH          = 256;
  localparam int AW             = 8;
  localparam int DW             = 8;
  localparam int CW             = 9;
  localparam int AFULL_LVL_DEF  = 224;
  localparam int AEMPTY_LVL_DEF = 32;
endpackage

// File: rtl/ram_fifo_ctrl.sv
// FIFO pointer/count/flag controller for an external RAM with registered, one-cycle read data.
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int AFULL_LVL  = AFULL_LVL_DEF,
  parameter int AEMPTY_LVL = AEMPTY_LVL_DEF
) (
  input  logic          i_rwclk,
  input  logic          i_resetn,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_pop,
  output logic [DW-1:0] o_rdata,
  output logic          o_rvalid,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_afull,
  output logic          o_aempty,
  output logic [CW-1:0] o_count,
  output logic          o_overflow,
  output logic          o_underflow,
  output logic          o_ram_wen,
  output logic          o_ram_ren,
  output logic [AW-1:0] o_ram_waddr,
  output logic [AW-1:0] o_ram_raddr,
  output logic [DW-1:0] o_ram_wd,
  input  logic [DW-1:0] i_ram_rd
);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_rvalid;
  logic          r_overflow;
  logic          r_underflow;

  logic w_full;
  logic w_empty;
  logic w_push_ok;
  logic w_pop_ok;

  // Flags come only from the registered count, so PUSH/POP never reach them combinationally.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // FULL blocks a push even alongside a pop, keeping read and write off the same address.
  assign w_push_ok = i_push & ~w_full  & ~i_clr;
  assign w_pop_ok  = i_pop  & ~w_empty & ~i_clr;

  always_ff @(posedge i_rwclk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_rvalid    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (i_clr) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_rvalid    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_rvalid <= w_pop_ok;
      if (i_push && w_full)  r_overflow  <= 1'b1;
      if (i_pop  && w_empty) r_underflow <= 1'b1;
    end
  end

  assign o_ram_wen   = w_push_ok;
  assign o_ram_ren   = w_pop_ok;
  assign o_ram_waddr = r_wptr;
  assign o_ram_raddr = r_rptr;
  assign o_ram_wd    = i_wdata;

  // The RAM holds its read register while REN is low, so RDATA stays put between pops.
  assign o_rdata     = i_ram_rd;
  assign o_rvalid    = r_rvalid;
  assign o_count     = r_count;
  assign o_full      = w_full;
  assign o_empty     = w_empty;
  assign o_afull     = (r_count >= CW'(AFULL_LVL));
  assign o_aempty    = (r_count <= CW'(AEMPTY_LVL));
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Randomized scoreboard bench for ram_fifo_ctrl with a behavioural RAM and a queue-based FIFO model.
module tb_ram_fifo_ctrl;
  import ram_fifo_ctrl_pkg::*;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_clr, i_push, i_pop;
  logic [DW-1:0] i_wdata;
  logic [DW-1:0] o_rdata, o_ram_wd, ram_rd;
  logic          o_rvalid, o_full, o_empty, o_afull, o_aempty;
  logic [CW-1:0] o_count;
  logic          o_overflow, o_underflow, o_ram_wen, o_ram_ren;
  logic [AW-1:0] o_ram_waddr, o_ram_raddr;

  ram_fifo_ctrl dut (
    .i_rwclk(clk), .i_resetn(rstn), .i_clr(i_clr), .i_push(i_push),
    .i_wdata(i_wdata), .i_pop(i_pop), .o_rdata(o_rdata), .o_rvalid(o_rvalid),
    .o_full(o_full), .o_empty(o_empty), .o_afull(o_afull), .o_aempty(o_aempty),
    .o_count(o_count), .o_overflow(o_overflow), .o_underflow(o_underflow),
    .o_ram_wen(o_ram_wen), .o_ram_ren(o_ram_ren), .o_ram_waddr(o_ram_waddr),
    .o_ram_raddr(o_ram_raddr), .o_ram_wd(o_ram_wd), .i_ram_rd(ram_rd)
  );

  always #5 clk = ~clk;

  // External 256x8 RAM with registered read data that holds while REN is low.
  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    if (o_ram_wen) mem[o_ram_waddr] <= o_ram_wd;
    if (o_ram_ren) ram_rd <= mem[o_ram_raddr];
  end

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  int m_wptr, m_rptr;
  bit m_ovf, m_udf, m_rvalid;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endfunction

  function automatic void model_clear();
    mq.delete();
    m_wptr = 0; m_rptr = 0;
    m_ovf = 0; m_udf = 0; m_rvalid = 0;
  endfunction

  // Monitor: every RVALID cycle must deliver the oldest outstanding popped byte.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && o_rvalid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL rvalid_unexpected: got rdata %0d with no pop outstanding at %0t", o_rdata, $time);
        end else begin
          chk("rdata", o_rdata, exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(input bit push, input bit pop, input bit clr, input logic [7:0] d);
    bit acc_push, acc_pop;
    int n;
    @(negedge clk);
    i_push = push; i_pop = pop; i_clr = clr; i_wdata = d;
    #1;
    n = mq.size();
    chk("count", o_count, n);
    chk("empty", o_empty, n == 0);
    chk("full", o_full, n == DEPTH);
    chk("afull", o_afull, n >= AFULL_LVL_DEF);
    chk("aempty", o_aempty, n <= AEMPTY_LVL_DEF);
    chk("overflow", o_overflow, m_ovf);
    chk("underflow", o_underflow, m_udf);
    chk("rvalid", o_rvalid, m_rvalid);
    acc_push = push && !clr && n < DEPTH;
    acc_pop  = pop && !clr && n > 0;
    chk("ram_wen", o_ram_wen, acc_push);
    chk("ram_ren", o_ram_ren, acc_pop);
    if (acc_push) begin
      chk("ram_waddr", o_ram_waddr, m_wptr);
      chk("ram_wd", o_ram_wd, d);
    end
    if (acc_pop) chk("ram_raddr", o_ram_raddr, m_rptr);
    if (clr) begin
      model_clear();
    end else begin
      if (push && n == DEPTH) m_ovf = 1;
      if (pop && n == 0) m_udf = 1;
      if (acc_pop) begin
        exp_q.push_back(mq.pop_front());
        m_rptr = (m_rptr + 1) % DEPTH;
      end
      if (acc_push) begin
        mq.push_back(d);
        m_wptr = (m_wptr + 1) % DEPTH;
      end
      m_rvalid = acc_pop;
    end
  endtask

  initial begin
    int pushed;
    bit p, q;
    rstn = 1'b0; i_clr = 0; i_push = 0; i_pop = 0; i_wdata = '0;
    model_clear();
    #1;
    chk("rst_empty", o_empty, 1);
    chk("rst_aempty", o_aempty, 1);
    chk("rst_full", o_full, 0);
    chk("rst_afull", o_afull, 0);
    chk("rst_wen", o_ram_wen, 0);
    chk("rst_ren", o_ram_ren, 0);
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;

    // Basic ordering
    step(1, 0, 0, 8'h11); step(1, 0, 0, 8'h22); step(1, 0, 0, 8'h33);
    step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
    step(0, 0, 0, 0); step(0, 0, 0, 0);

    // Fill to full, overflow, push+pop while full, then flush
    repeat (256) step(1, 0, 0, 8'($urandom));
    step(1, 0, 0, 8'hEE);
    step(1, 1, 0, 8'hDD);
    step(0, 0, 0, 0);
    repeat (5) step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Wrap with occupancy held in 1..4
    step(1, 0, 0, 8'($urandom));
    pushed = 1;
    while (pushed < 300) begin
      p = (mq.size() < 4) && ($urandom_range(0, 1) == 1);
      q = (mq.size() > 1) && ($urandom_range(0, 1) == 1);
      if (p) pushed++;
      step(p, q, 0, 8'($urandom));
    end
    while (mq.size() > 0) step(0, 1, 0, 0);
    step(0, 0, 0, 0);

    // Pop while empty, alone and with a push
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(1, 1, 0, 8'h5A);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);

    // Threshold crossings around 224 and 32
    step(0, 0, 1, 0);
    repeat (230) step(1, 0, 0, 8'($urandom));
    while (mq.size() > 20) step(0, 1, 0, 0);
    step(0, 0, 0, 0);

    // Random traffic in phases biased toward filling and draining
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 400; i++) begin
        p = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 70 : 30));
        q = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 30 : 70));
        step(p, q, $urandom_range(0, 199) == 0, 8'($urandom));
      end
    end

    // Reset mid-pop at count 10
    step(0, 0, 1, 0);
    repeat (10) step(1, 0, 0, 8'($urandom));
    step(0, 0, 0, 0);
    @(negedge clk);
    i_pop = 1'b1;
    #1 chk("midpop_ren", o_ram_ren, 1);
    #1 rstn = 1'b0;
    #1;
    chk("midrst_count", o_count, 0);
    chk("midrst_empty", o_empty, 1);
    chk("midrst_aempty", o_aempty, 1);
    chk("midrst_ren", o_ram_ren, 0);
    chk("midrst_wen", o_ram_wen, 0);
    chk("midrst_rvalid", o_rvalid, 0);
    i_pop = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    step(1, 0, 0, 8'hAB);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);

    // CLR with PUSH held
    step(1, 0, 0, 8'h01);
    step(1, 0, 0, 8'h02);
    step(1, 0, 1, 8'h03);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    chk("outstanding_pops", exp_q.size(), 0);
    i_push = 0; i_pop = 0; i_clr = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
